// File: rtl/mcb_cmd_arbiter.sv
// rtl/mcb_cmd_arbiter.sv - two-requester arbiter for the shared MCB user command port
//
// Purpose: picks one pending burst request (write or read), latches its
// address and burst length, and issues a single command strobe to the MCB
// once the command FIFO has room. A write is only considered once the MCB
// write-data FIFO already holds the whole burst.
//
// Build option: MCB_ARB_ROUND_ROBIN_EN
//   defined   - simultaneous eligible requests alternate (write wins after a read)
//   undefined - fixed priority, an eligible write always wins
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   wr_req_i/addr/bl    write burst request, start address, length-1
//   wr_gnt_o            one-cycle pulse when the write command is issued
//   rd_req_i/addr/bl    read burst request, start address, length-1
//   rd_gnt_o            one-cycle pulse when the read command is issued
//   mcb_wr_count_i      words held in the MCB write-data FIFO
//   mcb_cmd_full_i      MCB command FIFO full
//   mcb_cmd_*_o         command strobe, instruction, address, burst length
//   busy_o              high whenever the arbiter is not idle
//   wr/rd_cmd_cnt_o     wrapping counts of issued write/read commands

module mcb_cmd_arbiter #(
   parameter int ADDR_W = 30,
   parameter int BL_W   = 6,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [BL_W-1:0]   wr_bl_i,
   output logic              wr_gnt_o,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [BL_W-1:0]   rd_bl_i,
   output logic              rd_gnt_o,
   input  logic [6:0]        mcb_wr_count_i,
   input  logic              mcb_cmd_full_i,
   output logic              mcb_cmd_en_o,
   output logic [2:0]        mcb_cmd_instr_o,
   output logic [ADDR_W-1:0] mcb_cmd_addr_o,
   output logic [BL_W-1:0]   mcb_cmd_bl_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  wr_cmd_cnt_o,
   output logic [CNT_W-1:0]  rd_cmd_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [2:0]       INSTR_WR = 3'b000;
   localparam logic [2:0]       INSTR_RD = 3'b001;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t              state_q;
   logic                last_was_wr_q;
   logic                wr_gnt_q, rd_gnt_q, cmd_en_q, busy_q;
   logic [2:0]          instr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [BL_W-1:0]     bl_q;
   logic [CNT_W-1:0]    wr_cnt_q, rd_cnt_q;

   // Words needed in the write-data FIFO before a write may go; the length
   // field is words-1, so widen before adding one to avoid wrapping at 63.
   logic [6:0] wr_need;
   logic       wr_elig, rd_elig, wr_wins_d;

   assign wr_need = 7'(wr_bl_i) + 7'd1;
   assign wr_elig = wr_req_i && (mcb_wr_count_i >= wr_need);
   assign rd_elig = rd_req_i;

`ifdef MCB_ARB_ROUND_ROBIN_EN
   // Under contention the side that did not win last time goes first.
   assign wr_wins_d = wr_elig && (!rd_elig || !last_was_wr_q);
`else
   assign wr_wins_d = wr_elig;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         last_was_wr_q <= 1'b0;
         wr_gnt_q      <= 1'b0;
         rd_gnt_q      <= 1'b0;
         cmd_en_q      <= 1'b0;
         busy_q        <= 1'b0;
         instr_q       <= 3'b000;
         addr_q        <= '0;
         bl_q          <= '0;
         wr_cnt_q      <= '0;
         rd_cnt_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (wr_wins_d) begin
                  instr_q <= INSTR_WR;
                  addr_q  <= {wr_addr_i[ADDR_W-1:4], 4'b0000};
                  bl_q    <= wr_bl_i;
                  busy_q  <= 1'b1;
                  state_q <= ST_ISSUE;
               end else if (rd_elig) begin
                  instr_q <= INSTR_RD;
                  addr_q  <= {rd_addr_i[ADDR_W-1:4], 4'b0000};
                  bl_q    <= rd_bl_i;
                  busy_q  <= 1'b1;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // The latched command is committed; only FIFO space gates it.
               if (!mcb_cmd_full_i) begin
                  cmd_en_q <= 1'b1;
                  if (instr_q == INSTR_WR) begin
                     wr_gnt_q      <= 1'b1;
                     wr_cnt_q      <= wr_cnt_q + CNT_ONE;
                     last_was_wr_q <= 1'b1;
                  end else begin
                     rd_gnt_q      <= 1'b1;
                     rd_cnt_q      <= rd_cnt_q + CNT_ONE;
                     last_was_wr_q <= 1'b0;
                  end
                  state_q <= ST_GAP;
               end
            end
            ST_GAP: begin
               // Dead cycle lets the granted requester drop or refresh req.
               cmd_en_q <= 1'b0;
               wr_gnt_q <= 1'b0;
               rd_gnt_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: begin
               cmd_en_q <= 1'b0;
               wr_gnt_q <= 1'b0;
               rd_gnt_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign wr_gnt_o        = wr_gnt_q;
   assign rd_gnt_o        = rd_gnt_q;
   assign mcb_cmd_en_o    = cmd_en_q;
   assign mcb_cmd_instr_o = instr_q;
   assign mcb_cmd_addr_o  = addr_q;
   assign mcb_cmd_bl_o    = bl_q;
   assign busy_o          = busy_q;
   assign wr_cmd_cnt_o    = wr_cnt_q;
   assign rd_cmd_cnt_o    = rd_cnt_q;

endmodule
